// File: rtl/ring_monitor.sv
// Qualifying monitor for a 16-bit one-hot ring counter: registers the sampled
// position as a binary code and tracks lock, loss-of-lock and wrap statistics.
module ring_monitor #(
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [0:15]      Q,
    input  logic             CLR,
    output logic [3:0]       C,
    output logic             VALID,
    output logic             LOCK,
    output logic             ERR,
    output logic [CNT_W-1:0] WRAPS,
    output logic [CNT_W-1:0] ERRCNT
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]       GOOD_MAX = 4'(LOCK_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [4:0]       hot_cnt_s;
    logic [3:0]       hot_code_s;
    logic             onehot_s;
    logic [3:0]       code_q, code_d;
    logic             valid_q;
    state_t           state_q, state_d;
    logic [3:0]       prev_q, prev_d;
    logic [3:0]       good_q, good_d;
    logic [3:0]       prev_plus1_s;
    logic             step_ok_s;
    logic             wrap_inc_s, err_inc_s;
    logic             lock_q, err_q;
    logic [CNT_W-1:0] wraps_q, wraps_d, errcnt_q, errcnt_d;

    // Stage-1 decode: OR-ing indices is exact whenever the sample is one-hot.
    always_comb begin
        hot_cnt_s  = 5'd0;
        hot_code_s = 4'd0;
        for (int i = 0; i < 16; i++) begin
            hot_cnt_s  = hot_cnt_s + {4'd0, Q[i]};
            hot_code_s = hot_code_s | (Q[i] ? 4'(i) : 4'd0);
        end
        onehot_s = (hot_cnt_s == 5'd1);
        if (onehot_s) begin
            code_d = hot_code_s;
        end else begin
            code_d = code_q;
        end
    end

    assign prev_plus1_s = prev_q + 4'd1;
    assign step_ok_s    = valid_q && (code_q == prev_plus1_s);

    // Stage-2 step checker working on the registered stage-1 sample.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        good_d     = good_q;
        wrap_inc_s = 1'b0;
        err_inc_s  = 1'b0;
        case (state_q)
            HUNT: begin
                if (valid_q) begin
                    prev_d  = code_q;
                    good_d  = 4'd0;
                    state_d = SYNC;
                end else begin
                    state_d = HUNT;
                end
            end
            SYNC: begin
                if (!valid_q) begin
                    state_d = HUNT;
                end else if (step_ok_s) begin
                    prev_d = code_q;
                    if (good_q == GOOD_MAX) begin
                        state_d = LOCKED;
                    end else begin
                        good_d = good_q + 4'd1;
                    end
                end else begin
                    prev_d = code_q;
                    good_d = 4'd0;
                end
            end
            LOCKED: begin
                if (step_ok_s) begin
                    prev_d     = code_q;
                    wrap_inc_s = (prev_q == 4'd15);
                end else begin
                    err_inc_s = 1'b1;
                    state_d   = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // Saturating statistics; a clear on the same edge beats an increment.
    always_comb begin
        if (CLR) begin
            wraps_d = '0;
        end else if (wrap_inc_s && (wraps_q != CNT_MAX)) begin
            wraps_d = wraps_q + CNT_ONE;
        end else begin
            wraps_d = wraps_q;
        end
        if (CLR) begin
            errcnt_d = '0;
        end else if (err_inc_s && (errcnt_q != CNT_MAX)) begin
            errcnt_d = errcnt_q + CNT_ONE;
        end else begin
            errcnt_d = errcnt_q;
        end
    end

    // All state and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            code_q   <= 4'd0;
            valid_q  <= 1'b0;
            state_q  <= HUNT;
            prev_q   <= 4'd0;
            good_q   <= 4'd0;
            lock_q   <= 1'b0;
            err_q    <= 1'b0;
            wraps_q  <= '0;
            errcnt_q <= '0;
        end else begin
            code_q   <= code_d;
            valid_q  <= onehot_s;
            state_q  <= state_d;
            prev_q   <= prev_d;
            good_q   <= good_d;
            lock_q   <= (state_d == LOCKED);
            err_q    <= err_inc_s;
            wraps_q  <= wraps_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign C      = code_q;
    assign VALID  = valid_q;
    assign LOCK   = lock_q;
    assign ERR    = err_q;
    assign WRAPS  = wraps_q;
    assign ERRCNT = errcnt_q;

endmodule
